// File: rtl/pcie_phy_pkg.sv
// Symbol-level constants and types shared by the transmit serializer and
// the receive-side aligner.
package pcie_phy_pkg;

    localparam int SYM_BITS  = 8;
    localparam int BIT_CNT_W = $clog2(SYM_BITS);

    typedef logic [SYM_BITS-1:0] sym_t;

    localparam sym_t K_COM = 8'hBC;

    // Which symbol enters the shift register at a load edge.
    typedef enum logic [1:0] {
        LOAD_SYNC,
        LOAD_DATA,
        LOAD_IDLE
    } load_sel_e;

endpackage

// File: rtl/par_serial_8_1.sv
// Byte-to-serial transmit stage: sends a COM sync burst after reset, then one
// byte per symbol slot MSB first, filling empty slots with COM.
module par_serial_8_1 #(
    parameter int                                SYNC_COMS = 4,
    parameter logic [pcie_phy_pkg::SYM_BITS-1:0] K_COM     = pcie_phy_pkg::K_COM
) (
    input  logic                                clk_32f,
    input  logic                                reset,
    input  logic [pcie_phy_pkg::SYM_BITS-1:0]   data_in,
    input  logic                                valid_in,
    output logic                                ready_in,
    output logic                                data_out,
    output logic                                sym_start,
    output logic                                valid_out,
    output logic                                synced
);

    localparam int SYM_BITS  = pcie_phy_pkg::SYM_BITS;
    localparam int BIT_CNT_W = pcie_phy_pkg::BIT_CNT_W;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = '1;
    localparam logic [BIT_CNT_W-1:0] BIT_STEP    = BIT_CNT_W'(1);
    localparam logic [3:0]           SYNC_TARGET = 4'(SYNC_COMS);
    localparam logic [3:0]           COM_STEP    = 4'd1;

    logic [SYM_BITS-1:0]    r_shr;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [3:0]             r_com_cnt;
    logic                   r_is_data;
    logic                   r_sym_start;

    logic                   w_load;
    logic                   w_synced;
    pcie_phy_pkg::load_sel_e w_load_sel;

    assign w_load   = (r_bit_cnt == LAST_BIT);
    // com_cnt only counts while below the target, so equality is sticky.
    assign w_synced = (r_com_cnt == SYNC_TARGET);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_load_sel = pcie_phy_pkg::LOAD_IDLE;
        if (r_com_cnt < SYNC_TARGET) begin
            w_load_sel = pcie_phy_pkg::LOAD_SYNC;
        end else if (valid_in) begin
            w_load_sel = pcie_phy_pkg::LOAD_DATA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_shr       <= '0;
            r_bit_cnt   <= LAST_BIT;
            r_com_cnt   <= '0;
            r_is_data   <= 1'b0;
            r_sym_start <= 1'b0;
        end else if (w_load) begin
            r_bit_cnt   <= '0;
            r_sym_start <= 1'b1;
            case (w_load_sel)
                pcie_phy_pkg::LOAD_SYNC: begin
                    r_shr     <= K_COM;
                    r_is_data <= 1'b0;
                    r_com_cnt <= r_com_cnt + COM_STEP;
                end
                pcie_phy_pkg::LOAD_DATA: begin
                    r_shr     <= data_in;
                    r_is_data <= 1'b1;
                end
                default: begin
                    r_shr     <= K_COM;
                    r_is_data <= 1'b0;
                end
            endcase
        end else begin
            r_shr       <= {r_shr[SYM_BITS-2:0], 1'b0};
            r_bit_cnt   <= r_bit_cnt + BIT_STEP;
            r_sym_start <= 1'b0;
        end
    end

    assign data_out  = r_shr[SYM_BITS-1];
    assign sym_start = r_sym_start;
    assign valid_out = r_is_data;
    assign synced    = w_synced;
    assign ready_in  = w_load && w_synced && !reset;

endmodule
